// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction; outputs decode the state register in the same cycle.
// Backpressure: none; the FSM free-runs, and reset gates every write-type strobe low at once.
module mips_multicycle_control #(
    parameter int N         = 32,
    parameter int ALU_CTL_W = 3
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 mem_wr_ena,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_CTL_W-1:0] alu_control,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic [N-1:0]         instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
    } state_t;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(3'b010);
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = ALU_CTL_W'(3'b110);
    localparam logic [ALU_CTL_W-1:0] ALU_AND = ALU_CTL_W'(3'b000);
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = ALU_CTL_W'(3'b001);
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = ALU_CTL_W'(3'b111);

    state_t               r_state;
    state_t               w_next;
    logic                 r_illegal;
    logic [N-1:0]         r_count;
    logic                 w_bad_op;
    logic                 w_bad_funct;
    logic                 w_retire;
    logic                 w_pc_write;
    logic                 w_branch;
    logic                 w_mem_wr;
    logic                 w_ir_write;
    logic                 w_reg_write;
    logic [ALU_CTL_W-1:0] w_funct_ctl;

    always_comb begin
        w_funct_ctl = ALU_ADD;
        w_bad_funct = 1'b0;
        case (funct)
            6'b100000: w_funct_ctl = ALU_ADD;
            6'b100010: w_funct_ctl = ALU_SUB;
            6'b100100: w_funct_ctl = ALU_AND;
            6'b100101: w_funct_ctl = ALU_OR;
            6'b101010: w_funct_ctl = ALU_SLT;
            default:   w_bad_funct = 1'b1;
        endcase
    end

    always_comb begin
        w_next   = S_FETCH;
        w_bad_op = 1'b0;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_EXECUTE;
                    6'b000100:            w_next = S_BRANCH;
                    6'b001000:            w_next = S_ADDIEX;
                    6'b000010:            w_next = S_JUMP;
                    default:              w_bad_op = 1'b1;
                endcase
            end
            S_MEMADR:  w_next = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_wr    = 1'b0;
        iord        = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        w_reg_write = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                w_mem_wr = 1'b1;
                w_retire = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = w_funct_ctl;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                w_branch    = 1'b1;
                pc_src      = 2'b01;
                w_retire    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by rstb so nothing commits while reset is asserted.
    assign mem_wr_ena  = w_mem_wr & rstb;
    assign ir_write    = w_ir_write & rstb;
    assign reg_write   = w_reg_write & rstb;
    assign pc_en       = (w_pc_write | (w_branch & zero)) & rstb;
    assign state       = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_DECODE && w_bad_op) || (r_state == S_EXECUTE && w_bad_funct))
                r_illegal <= 1'b1;
            if (w_retire)
                r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class through its state sequence.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        rstb;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_wr_ena, iord, ir_write, pc_en, alu_src_a;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_control;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_control #(.N(32), .ALU_CTL_W(3)) dut (
        .clk(clk), .rstb(rstb), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_wr_ena(mem_wr_ena), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0; opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d illegal=%b count=%0d, want 0/0/0", state, illegal, instr_count);
        end
        checks++;
        if ({mem_wr_ena, ir_write, pc_en, reg_write} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: wr/ir/pc/rw=%b, want 0000", {mem_wr_ena, ir_write, pc_en, reg_write});
        end
    endtask

    task automatic test_lw();
        int exp_s[5] = '{0, 1, 2, 3, 4};
        rstb = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 4'(exp_s[i])) begin
                failures++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            checks++;
            if (reg_write !== (i == 4) || (i == 4 && mem_to_reg !== 1'b1)) begin
                failures++;
                $display("FAIL lw_regwrite[%0d]: reg_write=%b mem_to_reg=%b", i, reg_write, mem_to_reg);
            end
            if (i == 0) begin
                checks++;
                if ({ir_write, pc_en, iord, alu_src_b, alu_control} !== {1'b1, 1'b1, 1'b0, 2'b01, 3'b010}) begin
                    failures++;
                    $display("FAIL lw_fetch: ir=%b pc_en=%b iord=%b srcb=%b alu=%b", ir_write, pc_en, iord, alu_src_b, alu_control);
                end
            end
            if (i == 3) begin
                checks++;
                if (iord !== 1'b1) begin
                    failures++;
                    $display("FAIL lw_memrd_iord: got %b want 1", iord);
                end
            end
            step();
        end
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd1) begin
            failures++;
            $display("FAIL lw_retire: state=%0d count=%0d want 0/1", state, instr_count);
        end
    endtask

    task automatic test_rtype();
        int exp_s[4] = '{0, 1, 6, 7};
        opcode = 6'b000000; funct = 6'b100010;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_s[i])) begin
                failures++;
                $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_control, alu_src_a, alu_src_b} !== {3'b110, 1'b1, 2'b00}) begin
                    failures++;
                    $display("FAIL rtype_exec: alu=%b srca=%b srcb=%b want 110/1/00", alu_control, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
                    failures++;
                    $display("FAIL rtype_wb: rw/dst/m2r=%b want 110", {reg_write, reg_dst, mem_to_reg});
                end
            end
            step();
        end
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd2) begin
            failures++;
            $display("FAIL rtype_retire: state=%0d count=%0d want 0/2", state, instr_count);
        end
    endtask

    task automatic test_beq();
        int exp_s[3] = '{0, 1, 8};
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (state !== 4'(exp_s[i])) begin
                    failures++;
                    $display("FAIL beq_state[z%0d,%0d]: got %0d want %0d", z, i, state, exp_s[i]);
                end
                if (i == 1) begin
                    checks++;
                    if ({alu_src_a, alu_src_b, pc_en} !== {1'b0, 2'b11, 1'b0}) begin
                        failures++;
                        $display("FAIL beq_decode: srca=%b srcb=%b pc_en=%b want 0/11/0", alu_src_a, alu_src_b, pc_en);
                    end
                end
                if (i == 2) begin
                    checks++;
                    if ({pc_en, pc_src, alu_control} !== {z[0], 2'b01, 3'b110}) begin
                        failures++;
                        $display("FAIL beq_branch[z%0d]: pc_en=%b pc_src=%b alu=%b", z, pc_en, pc_src, alu_control);
                    end
                end
                step();
            end
            checks++;
            if (state !== 4'd0 || instr_count !== 32'(4 - z)) begin
                failures++;
                $display("FAIL beq_retire[z%0d]: state=%0d count=%0d want 0/%0d", z, state, instr_count, 4 - z);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_sw_reset();
        int exp_s[4] = '{0, 1, 2, 5};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_s[i]) || mem_wr_ena !== (i == 3) || (i == 3 && iord !== 1'b1)) begin
                failures++;
                $display("FAIL sw_seq[%0d]: state=%0d wr=%b iord=%b want %0d", i, state, mem_wr_ena, iord, exp_s[i]);
            end
            step();
        end
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd5) begin
            failures++;
            $display("FAIL sw_retire: state=%0d count=%0d want 0/5", state, instr_count);
        end
        step();
        step();
        checks++;
        if (state !== 4'd2) begin
            failures++;
            $display("FAIL sw2_memadr: got %0d want 2", state);
        end
        rstb = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || mem_wr_ena !== 1'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL sw2_abort: state=%0d wr=%b count=%0d want 0/0/0", state, mem_wr_ena, instr_count);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (mem_wr_ena !== 1'b0 || state !== 4'd0) begin
                failures++;
                $display("FAIL sw2_hold[%0d]: wr=%b state=%0d want 0/0", i, mem_wr_ena, state);
            end
        end
        rstb = 1'b1;
        #1;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        step();
        checks++;
        if (state !== 4'd1 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL ill_decode: state=%0d illegal=%b want 1/0", state, illegal);
        end
        step();
        checks++;
        if (state !== 4'd0 || illegal !== 1'b1 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL ill_flag: state=%0d illegal=%b count=%0d want 0/1/0", state, illegal, instr_count);
        end
    endtask

    task automatic test_back_to_back();
        int exp_s[11] = '{0, 1, 9, 10, 0, 1, 11, 0, 1, 6, 7};
        logic [5:0] ops[11] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                                 6'b000010, 6'b000010, 6'b000010,
                                 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        funct = 6'b101010;
        for (int i = 0; i < 11; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (state !== 4'(exp_s[i])) begin
                failures++;
                $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            if (exp_s[i] == 10) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
                    failures++;
                    $display("FAIL b2b_addiwb: rw/dst/m2r=%b want 100", {reg_write, reg_dst, mem_to_reg});
                end
            end
            if (exp_s[i] == 11) begin
                checks++;
                if ({pc_en, pc_src} !== 3'b110) begin
                    failures++;
                    $display("FAIL b2b_jump: pc_en=%b pc_src=%b want 1/10", pc_en, pc_src);
                end
            end
            if (exp_s[i] == 6) begin
                checks++;
                if (alu_control !== 3'b111) begin
                    failures++;
                    $display("FAIL b2b_slt: alu=%b want 111", alu_control);
                end
            end
            step();
        end
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd3 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL b2b_retire: state=%0d count=%0d illegal=%b want 0/3/1", state, instr_count, illegal);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_reset();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
